// File: rtl/output_port_arbiter_ydma.sv
// output_port_arbiter_ydma
// Round-robin arbiter with a per-port burst limit. It picks one of the
// per-port FWFT packet FIFOs, pops the head with a one-hot strobe and
// registers the packet onto a single valid/ack link.
module output_port_arbiter_ydma #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_OUT_PORTS = 7,
  parameter int NUM_SEL_BITS  = 3,
  parameter int MAX_BURST     = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] internal_out,
  input  logic [NUM_OUT_PORTS-1:0]             empty,
  output logic [NUM_OUT_PORTS-1:0]             rd_en_sel,
  output logic [PACKET_BITS-1:0]               dout,
  output logic                                 vld_out,
  input  logic                                 ack_in,
  output logic [NUM_SEL_BITS-1:0]              grant_port
);

  localparam int BURST_BITS = $clog2(MAX_BURST + 1);
  localparam logic [BURST_BITS-1:0] MAX_BURST_C = BURST_BITS'(MAX_BURST);
  localparam logic [BURST_BITS-1:0] BURST_ONE_C = BURST_BITS'(1);

  // Port index cur+k, wrapped into 0..NUM_OUT_PORTS-1.
  function automatic logic [NUM_SEL_BITS-1:0] wrap_add(
    input logic [NUM_SEL_BITS-1:0] base,
    input int                      k
  );
    int t;
    t = int'(base) + k;
    if (t >= NUM_OUT_PORTS) begin
      t = t - NUM_OUT_PORTS;
    end else begin
      t = t;
    end
    return NUM_SEL_BITS'(t);
  endfunction

  logic [NUM_SEL_BITS-1:0] cur_r;
  logic [BURST_BITS-1:0]   burst_cnt_r;
  logic [PACKET_BITS-1:0]  dout_r;
  logic                    vld_r;

  logic                    load_en_s;
  logic                    grant_vld_s;
  logic [NUM_SEL_BITS-1:0] grant_idx_s;
  logic [BURST_BITS-1:0]   next_burst_s;
  logic                    rot_found_s;
  logic [NUM_SEL_BITS-1:0] rot_idx_s;
  logic [NUM_SEL_BITS-1:0] cand_s;

  // The link can take a new packet when it is idle or the current one leaves.
  assign load_en_s = !vld_r || ack_in;

  // Rotation search: first non-empty port after cur, never cur itself.
  always_comb begin
    rot_found_s = 1'b0;
    rot_idx_s   = cur_r;
    cand_s      = cur_r;
    for (int k = 1; k < NUM_OUT_PORTS; k++) begin
      cand_s = wrap_add(cur_r, k);
      if (!rot_found_s && !empty[cand_s]) begin
        rot_found_s = 1'b1;
        rot_idx_s   = cand_s;
      end else begin
        rot_found_s = rot_found_s;
      end
    end
  end

  // Grant decision: stay within burst, else rotate, else fall back to cur.
  always_comb begin
    grant_vld_s  = 1'b0;
    grant_idx_s  = cur_r;
    next_burst_s = burst_cnt_r;
    if (!empty[cur_r] && (burst_cnt_r < MAX_BURST_C)) begin
      grant_vld_s  = 1'b1;
      grant_idx_s  = cur_r;
      next_burst_s = burst_cnt_r + BURST_ONE_C;
    end else if (rot_found_s) begin
      grant_vld_s  = 1'b1;
      grant_idx_s  = rot_idx_s;
      next_burst_s = BURST_ONE_C;
    end else if (!empty[cur_r]) begin
      // Sole requester with an exhausted burst keeps the link.
      grant_vld_s  = 1'b1;
      grant_idx_s  = cur_r;
      next_burst_s = BURST_ONE_C;
    end else begin
      grant_vld_s  = 1'b0;
      grant_idx_s  = cur_r;
      next_burst_s = {BURST_BITS{1'b0}};
    end
  end

  // One-hot pop strobe, suppressed during reset and while the link stalls.
  always_comb begin
    rd_en_sel = {NUM_OUT_PORTS{1'b0}};
    if (reset && load_en_s && grant_vld_s) begin
      rd_en_sel[grant_idx_s] = 1'b1;
    end else begin
      rd_en_sel = {NUM_OUT_PORTS{1'b0}};
    end
  end

  // Output register and arbitration state; a held packet is dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_r       <= {NUM_SEL_BITS{1'b0}};
      burst_cnt_r <= {BURST_BITS{1'b0}};
      dout_r      <= {PACKET_BITS{1'b0}};
      vld_r       <= 1'b0;
    end else if (load_en_s) begin
      if (grant_vld_s) begin
        dout_r      <= internal_out[int'(grant_idx_s)*PACKET_BITS +: PACKET_BITS];
        vld_r       <= 1'b1;
        cur_r       <= grant_idx_s;
        burst_cnt_r <= next_burst_s;
      end else begin
        vld_r       <= 1'b0;
        burst_cnt_r <= {BURST_BITS{1'b0}};
      end
    end else begin
      vld_r <= vld_r;
    end
  end

  assign dout       = dout_r;
  assign vld_out    = vld_r;
  assign grant_port = cur_r;

endmodule

// File: doc/output_port_arbiter_ydma.md
Name: output_port_arbiter_ydma

Overview:
- Downstream stage of the ydma output port cluster.
- Round-robin arbitrates among NUM_OUT_PORTS per-port packet FIFOs (FWFT, exposed as internal_out/empty), pops the winner via one-hot rd_en_sel, and registers one packet per cycle onto a single valid/ack link toward the leaf interface/network.
- A per-port burst limit bounds how long one port can hold the link.

Parameters:
- PACKET_BITS, 97, width of one packet.
- NUM_OUT_PORTS, 7, number of arbitrated output ports.
- NUM_SEL_BITS, 3, width of the port index; must satisfy 2**NUM_SEL_BITS >= NUM_OUT_PORTS.
- MAX_BURST, 4, maximum consecutive grants to one port while another port is non-empty; must be >= 1.

Ports:
- clk, input, 1, clock; all state is on the rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- internal_out, input, PACKET_BITS*NUM_OUT_PORTS, head packet of each port FIFO; slice i is [PACKET_BITS*(i+1)-1:PACKET_BITS*i]; FWFT, so it is valid whenever empty[i]=0.
- empty, input, NUM_OUT_PORTS, per-port FIFO empty flag.
- rd_en_sel, output, NUM_OUT_PORTS, one-hot pop strobe to the port FIFOs.
- dout, output, PACKET_BITS, registered outgoing packet.
- vld_out, output, 1, dout is valid.
- ack_in, input, 1, downstream accepts dout this cycle.
- grant_port, output, NUM_SEL_BITS, index of the port that supplied the current dout.

Behaviour:
- Reset (reset=0, asynchronous): vld_out=0, dout=0, grant_port=0, burst_cnt=0, rd_en_sel=0. rd_en_sel is forced to 0 combinationally while reset=0. A packet held in dout when reset asserts is dropped.
- Transfer: occurs in any cycle with vld_out && ack_in.
- load_en: defined as (!vld_out || ack_in), combinational.
- While vld_out=1 && ack_in=0: dout and grant_port hold stable, and rd_en_sel=0.
- Internal state: cur (= grant_port) and burst_cnt (width clog2(MAX_BURST+1)).
- Grant selection, evaluated only when load_en=1:
  1. Stay: if empty[cur]=0 and burst_cnt < MAX_BURST, grant cur; burst_cnt <= burst_cnt+1.
  2. Rotate: otherwise search j = cur+1, cur+2, ... modulo NUM_OUT_PORTS. The first j with empty[j]=0 and j != cur wins; cur <= j and burst_cnt <= 1.
  3. Fallback: if the only non-empty port is cur and its burst is exhausted, grant cur with burst_cnt <= 1.
  4. No requests: if all ports are empty, nothing is granted, burst_cnt <= 0, cur is unchanged.
- Index wrap: indices beyond NUM_OUT_PORTS-1 are never generated; NUM_OUT_PORTS-1 wraps to 0.
- On grant g:
  - rd_en_sel = one-hot(g) in the same cycle (combinational from state, empty and ack_in).
  - Next edge: dout <= internal_out slice g, vld_out <= 1, grant_port <= g.
- load_en=1 with no grant: vld_out <= 0 and dout holds its old value (don't care).
- Latency: a pop in cycle N gives vld_out=1 with that packet in cycle N+1.
- Throughput: 1 packet/cycle while ack_in=1 and any port is non-empty.
- Invariants:
  - rd_en_sel has at most one bit set.
  - rd_en_sel[i]=1 never coincides with empty[i]=1.
  - No packet is popped without being presented on dout.
  - No packet is presented twice.
  - Packet order within a port is preserved.
- If empty[g] changes in the same cycle as the grant: the decision uses the current-cycle empty only.
- Starvation bound: a continuously non-empty port is granted within (NUM_OUT_PORTS-1)*MAX_BURST transfers.

Test Plan:
1. Reset: hold reset=0 with all FIFOs non-empty -> rd_en_sel=0, vld_out=0, dout=0. Release reset with ack_in=1 -> first pop rd_en_sel=7'b0000001, and vld_out=1 on the next cycle with dout = port0 head.
2. Burst and rotate: ports 0 and 3 non-empty, ack_in=1, MAX_BURST=4 -> grant_port sequence 0,0,0,0,3,3,3,3,0,...; exactly one rd_en_sel bit set per cycle.
3. Backpressure: ack_in=0 for 5 cycles with vld_out=1 -> dout and grant_port stable, rd_en_sel=0 throughout. ack_in=1 -> the next packet appears one cycle later with no bubble.
4. Single requester: only port 6 non-empty with 10 packets, ack_in=1 -> 10 consecutive transfers from port 6, including past MAX_BURST; the cycle after the last packet gives vld_out=0 and burst_cnt=0.
5. Wrap and empty edge: cur=6, port 6 empties, port 1 non-empty -> next grant is 1 with burst_cnt=1. All ports empty -> vld_out falls after the final transfer.
6. Reset mid-burst: assert reset while vld_out=1 and burst_cnt=2 -> vld_out=0 immediately (asynchronous). After release, arbitration restarts at port 0 with burst_cnt=0.
